atm_pin_auth: RTL and testbench
===============================

# atm_pin_auth

Session front-end of the ATM controller: it accepts card insertion, language selection and PIN entry, then grants or denies access to the transaction menu. It sits directly upstream of the transaction controller. Its `o_pin` is the authentication qualifier that the controller requires before it acts on `i_transactionMenu`, and its `o_lang` selects the message set.

## Interface
Parameters:
- `STORED_PIN`, default 4'b1010: PIN value accepted as correct.
- `MAX_TRIES`, default 3: wrong entries allowed before lockout; legal range 1..3.
- `TIMEOUT_CYC`, default 16: idle cycles allowed in LANG/PIN before the session is aborted; legal range 2..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_cardIn` in 1: level; card present in slot.
- `i_langValid` in 1: one-cycle strobe; language choice on `i_lang` is valid.
- `i_lang` in 1: 1 = English, 0 = Arabic.
- `i_passwdValid` in 1: one-cycle strobe; `i_passwd` is valid.
- `i_passwd` in 4: entered PIN.
- `i_sessionEnd` in 1: one-cycle strobe from the transaction controller; transaction is finished.
- `o_pin` out 1: level; session is authenticated.
- `o_lang` out 1: latched language choice.
- `o_wrongPin` out 1: one-cycle pulse on each rejected PIN.
- `o_locked` out 1: level; card is retained and the block is locked.
- `o_attemptsLeft` out 2: remaining tries.
- `o_timeout` out 1: one-cycle pulse when a session is aborted for inactivity.

## Operation
- States: IDLE, LANG, PIN, AUTH, LOCKED.
- Reset: state IDLE. `o_pin`=0, `o_lang`=1, `o_wrongPin`=0, `o_locked`=0, `o_attemptsLeft`=MAX_TRIES, `o_timeout`=0.
- IDLE:
  - `i_cardIn`=1 → LANG.
  - `o_attemptsLeft` reloads to MAX_TRIES.
- LANG: `i_langValid` → latch `i_lang` into `o_lang`, then go to PIN.
- PIN:
  - `i_passwdValid` with `i_passwd`==STORED_PIN → AUTH.
  - `i_passwdValid` with a mismatch → pulse `o_wrongPin` and decrement `o_attemptsLeft`.
  - If the decremented value is 0 → LOCKED; otherwise stay in PIN.
- AUTH:
  - `o_pin`=1.
  - `i_sessionEnd` → IDLE.
- LOCKED:
  - `o_locked`=1 and `o_pin`=0.
  - Only `rst` exits; card removal is ignored.
- Card removal: `i_cardIn`=0 in LANG, PIN or AUTH → IDLE. This has priority over every strobe in the same cycle.
- Strobe filtering: strobes not matching the current state are ignored. Examples: `i_passwdValid` in LANG, `i_langValid` in PIN.
- Same-cycle strobes: if `i_langValid` and `i_passwdValid` arrive together in LANG, only the language is taken.
- Counter width: `o_attemptsLeft` is 2-bit unsigned and never wraps below 0.

## Timing
- All outputs are registered.
- Latency from strobe to response is 1 cycle:
  - `i_passwdValid` at edge N → `o_pin` or `o_wrongPin` visible after edge N+1.
  - `i_sessionEnd` at edge N → `o_pin`=0 after edge N+1.
- Removing the card in AUTH drops `o_pin` one cycle later.
- `o_wrongPin` and `o_timeout` are exactly one cycle wide.
- Reset asserted mid-session: on the next edge every output returns to its reset value, including `o_locked`.

## Configuration
- Macro: `ATM_PIN_TIMEOUT_EN`.
- Defined:
  - An idle counter runs in LANG and PIN and clears on any accepted strobe and on each state change.
  - When it reaches TIMEOUT_CYC-1, the next edge moves to IDLE and pulses `o_timeout`.
  - The lost attempts are not restored until IDLE reloads them.
- Undefined:
  - No counter is built.
  - `o_timeout` is tied to 0.
  - LANG and PIN wait indefinitely.

## Structure
- Shared package `atm_pkg`:
  - State enum `atm_auth_state_t`.
  - `LANG_EN`=1'b1 and `LANG_AR`=1'b0.
  - Width constant for the attempts counter.
- Sub-module `atm_idle_timer`, compiled only under `ATM_PIN_TIMEOUT_EN`:
  - Inputs: `clk`, `rst`, enable, clear.
  - Output: one-cycle expiry pulse.
  - Parameter: TIMEOUT_CYC.
- All other logic lives in `atm_pin_auth`.

## Test plan
- Correct PIN: card in, `i_langValid` with `i_lang`=0, `i_passwd`=4'b1010 → `o_lang`=0 and `o_pin`=1 one cycle after the PIN strobe. Then `i_sessionEnd` → `o_pin`=0 next cycle, state IDLE.
- Wrong then right: `i_passwd`=4'b0001 → `o_wrongPin` pulse, `o_attemptsLeft`=2. Then 4'b1010 → `o_pin`=1 and `o_attemptsLeft` holds 2.
- Lockout: three wrong PINs → `o_attemptsLeft` steps 2,1,0 and `o_locked`=1 after the third. A later correct PIN and card removal leave `o_locked`=1; `rst` clears it.
- Card removal racing a PIN: `i_cardIn`=0 in the same cycle as `i_passwdValid` with 4'b1010 in PIN → IDLE, `o_pin` stays 0. Reinsertion shows `o_attemptsLeft`=3.
- Timeout (`ATM_PIN_TIMEOUT_EN`, TIMEOUT_CYC=16): enter PIN and wait with no strobes → `o_timeout` pulse, state IDLE. A strobe at cycle 10 restarts the count.
- Reset mid-AUTH: assert `rst` while `o_pin`=1 → all outputs at reset values after the next edge.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session front-end: FSM state encoding,
// language codes and the attempts counter width.
package atm_pkg;

  // Width of the remaining-tries counter (supports up to 3 tries).
  localparam int unsigned ATTEMPT_W = 2;

  // Language codes as carried on i_lang / o_lang.
  localparam logic LANG_EN = 1'b1;
  localparam logic LANG_AR = 1'b0;

  // Legacy-compatible state encodings.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LANG   = 3'd1;
  localparam logic [2:0] ST_PIN    = 3'd2;
  localparam logic [2:0] ST_AUTH   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StLang   = ST_LANG,
    StPin    = ST_PIN,
    StAuth   = ST_AUTH,
    StLocked = ST_LOCKED
  } atm_auth_state_t;

  // Saturating decrement: the counter never wraps below zero.
  function automatic logic [ATTEMPT_W-1:0] attempts_dec(input logic [ATTEMPT_W-1:0] cur);
    logic [ATTEMPT_W-1:0] res;
    res = cur;
    if (cur != '0) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Inactivity timer for the LANG/PIN states. Only built when
// ATM_PIN_TIMEOUT_EN is defined. Counts enabled cycles without a clear
// and pulses expire for one cycle on the TIMEOUT_CYC-th such cycle.
`ifdef ATM_PIN_TIMEOUT_EN
module atm_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;

  // Expiry is suppressed by a same-cycle clear so an accepted strobe wins.
  always_comb begin
    expire = enable && !clear && (cnt_q == LastCnt);
  end

  // Idle counter: restarts whenever disabled, cleared or expired.
  always_ff @(posedge clk) begin
    if (rst || !enable || clear || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/atm_pin_auth.sv
// ATM session front-end: card insertion, language selection, PIN entry
// and lockout. All outputs are registered.
// Optional inactivity timeout is enabled by defining ATM_PIN_TIMEOUT_EN;
// without it o_timeout is tied low and LANG/PIN wait indefinitely.
module atm_pin_auth
  import atm_pkg::*;
#(
  parameter logic [3:0]  STORED_PIN  = 4'b1010,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cardIn,
  input  logic                 i_langValid,
  input  logic                 i_lang,
  input  logic                 i_passwdValid,
  input  logic [3:0]           i_passwd,
  input  logic                 i_sessionEnd,
  output logic                 o_pin,
  output logic                 o_lang,
  output logic                 o_wrongPin,
  output logic                 o_locked,
  output logic [ATTEMPT_W-1:0] o_attemptsLeft,
  output logic                 o_timeout
);

  localparam logic [ATTEMPT_W-1:0] MaxTries = ATTEMPT_W'(MAX_TRIES);

  atm_auth_state_t       state_q, state_d;
  logic [ATTEMPT_W-1:0]  attempts_q, attempts_d;
  logic                  pin_q, lang_q, wrong_q, locked_q;

  logic lang_take, pin_take, pin_ok, pin_bad, end_take;
  logic expire;

  // Strobe qualification: only strobes matching the state count, and a
  // missing card masks all of them.
  always_comb begin
    lang_take = (state_q == StLang) && i_cardIn && i_langValid;
    pin_take  = (state_q == StPin) && i_cardIn && i_passwdValid;
    pin_ok    = pin_take && (i_passwd == STORED_PIN);
    pin_bad   = pin_take && (i_passwd != STORED_PIN);
    end_take  = (state_q == StAuth) && i_cardIn && i_sessionEnd;
  end

  // Next-state logic; card removal takes priority over every strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_cardIn) begin
          state_d = StLang;
        end
      end
      StLang: begin
        if (!i_cardIn) begin
          state_d = StIdle;
        end else if (lang_take) begin
          state_d = StPin;
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      StPin: begin
        if (!i_cardIn) begin
          state_d = StIdle;
        end else if (pin_ok) begin
          state_d = StAuth;
        end else if (pin_bad && (attempts_dec(attempts_q) == '0)) begin
          state_d = StLocked;
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      StAuth: begin
        if (!i_cardIn || end_take) begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        // Card is retained; only reset leaves this state.
        state_d = StLocked;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Attempts counter: reload while idle, step down on each rejected PIN.
  always_comb begin
    attempts_d = attempts_q;
    if (state_q == StIdle) begin
      attempts_d = MaxTries;
    end else if (pin_bad) begin
      attempts_d = attempts_dec(attempts_q);
    end
  end

  // State and registered outputs, derived from the next state so they
  // appear one cycle after the causing strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      attempts_q <= MaxTries;
      pin_q      <= 1'b0;
      lang_q     <= LANG_EN;
      wrong_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      pin_q      <= (state_d == StAuth);
      locked_q   <= (state_d == StLocked);
      wrong_q    <= pin_bad;
      if (lang_take) begin
        lang_q <= i_lang;
      end
    end
  end

`ifdef ATM_PIN_TIMEOUT_EN
  logic timer_en, timer_clr, timeout_q;

  // Timer runs only in LANG/PIN; any accepted strobe restarts it. Leaving
  // those states disables it, which also clears the count.
  always_comb begin
    timer_en  = (state_q == StLang) || (state_q == StPin);
    timer_clr = lang_take || pin_take;
  end

  atm_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (timer_en),
    .clear  (timer_clr),
    .expire (expire)
  );

  // Timeout pulse only when expiry actually drives the abort (card present).
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire && i_cardIn;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_pin          = pin_q;
  assign o_lang         = lang_q;
  assign o_wrongPin     = wrong_q;
  assign o_locked       = locked_q;
  assign o_attemptsLeft = attempts_q;

endmodule

// File: tb/tb_atm_pin_auth.sv
// Directed, table-driven bench for atm_pin_auth (default parameters).
// Each table row is one clock: inputs applied, outputs checked after the edge.
module tb_atm_pin_auth;

  logic       clk;
  logic       rst;
  logic       i_cardIn, i_langValid, i_lang, i_passwdValid, i_sessionEnd;
  logic [3:0] i_passwd;
  logic       o_pin, o_lang, o_wrongPin, o_locked, o_timeout;
  logic [1:0] o_attemptsLeft;

  int n_vec;
  int n_err;

  atm_pin_auth dut (
    .clk            (clk),
    .rst            (rst),
    .i_cardIn       (i_cardIn),
    .i_langValid    (i_langValid),
    .i_lang         (i_lang),
    .i_passwdValid  (i_passwdValid),
    .i_passwd       (i_passwd),
    .i_sessionEnd   (i_sessionEnd),
    .o_pin          (o_pin),
    .o_lang         (o_lang),
    .o_wrongPin     (o_wrongPin),
    .o_locked       (o_locked),
    .o_attemptsLeft (o_attemptsLeft),
    .o_timeout      (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, card, lv, lang, pv;
    logic [3:0] pw;
    logic       se;
    logic [6:0] exp; // {pin, lang, wrong, locked, att[1:0], timeout}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic c, input logic lv, input logic l,
                              input logic pv, input logic [3:0] pw, input logic se,
                              input logic ep, input logic el, input logic ew,
                              input logic ek, input logic [1:0] ea, input logic et);
    vec_t v;
    v.rst = r; v.card = c; v.lv = lv; v.lang = l; v.pv = pv; v.pw = pw; v.se = se;
    v.exp = {ep, el, ew, ek, ea, et};
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {o_pin, o_lang, o_wrongPin, o_locked, o_attemptsLeft, o_timeout};
  endfunction

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic drive(input logic r, input logic c, input logic lv, input logic l,
                       input logic pv, input logic [3:0] pw, input logic se);
    rst = r; i_cardIn = c; i_langValid = lv; i_lang = l;
    i_passwdValid = pv; i_passwd = pw; i_sessionEnd = se;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: pin/lang/wrong/locked/att/tmo got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; i_cardIn = 1'b0; i_langValid = 1'b0; i_lang = 1'b0;
    i_passwdValid = 1'b0; i_passwd = 4'd0; i_sessionEnd = 1'b0;

    //              rst c lv l pv pw       se   pin lang wr lk att   tmo
    // Reset, then correct PIN with Arabic; lang+passwd together takes only lang.
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'b1010, 0,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1010, 0,  1, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  1, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 1,  0, 0, 0, 0, 2'd3, 0));
    // Wrong then right, then card removal from AUTH.
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 0,  0, 1, 1, 0, 2'd2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1010, 0,  1, 1, 0, 0, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    // Lockout after three wrong PINs; correct PIN and removal ignored; rst clears.
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0000, 0,  0, 0, 1, 0, 2'd2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1111, 0,  0, 0, 1, 0, 2'd1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0101, 0,  0, 0, 1, 1, 2'd0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1010, 0,  0, 0, 0, 1, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 1, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 0,  0, 0, 0, 1, 2'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    // Card removal racing a correct PIN; reinsertion reloads attempts.
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0011, 0,  0, 1, 1, 0, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1010, 0,  0, 1, 0, 0, 2'd2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    // passwd strobe ignored in LANG; sessionEnd ignored in PIN; reset mid-AUTH.
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1010, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 1,  0, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1010, 0,  1, 0, 0, 0, 2'd3, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0,  0, 1, 0, 0, 2'd3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].card, vecs[i].lv, vecs[i].lang, vecs[i].pv, vecs[i].pw,
            vecs[i].se);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

`ifdef ATM_PIN_TIMEOUT_EN
    // Idle in PIN: pulse on the 16th idle cycle, then back in IDLE.
    drive(1, 0, 0, 0, 0, 4'd0, 0);
    drive(0, 1, 0, 0, 0, 4'd0, 0);
    drive(0, 1, 1, 1, 0, 4'd0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 0);
      check_bit($sformatf("tmo_idle%0d", k), o_timeout, (k == 16));
    end
    drive(0, 1, 0, 0, 0, 4'd0, 0);
    check_bit("tmo_width", o_timeout, 1'b0);
    // Now in LANG; a PIN strobe after 10 idle cycles restarts the count.
    drive(0, 1, 1, 1, 0, 4'd0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 0);
    end
    drive(0, 1, 0, 0, 1, 4'b0001, 0);
    check("tmo_strobe", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0});
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 0);
      check_bit($sformatf("tmo_restart%0d", k), o_timeout, (k == 16));
    end
    check("tmo_att_kept", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1});
    drive(0, 1, 0, 0, 0, 4'd0, 0);
    check("tmo_reload", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0});
`else
    // No timer: PIN waits indefinitely, then a correct PIN still authenticates.
    drive(1, 0, 0, 0, 0, 4'd0, 0);
    drive(0, 1, 0, 0, 0, 4'd0, 0);
    drive(0, 1, 1, 1, 0, 4'd0, 0);
    for (int k = 1; k <= 40; k++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 0);
      if (k % 8 == 0) begin
        check($sformatf("wait%0d", k), outs(), {1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0});
      end
    end
    drive(0, 1, 0, 0, 1, 4'b1010, 0);
    check("late_pin", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
